// File: rtl/ysyx_22050133_fetch_queue_pkg.sv
// Shared constants for the decoupled instruction-fetch front end.
package ysyx_22050133_fetch_queue_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
    localparam int unsigned INST_W           = 32;
    localparam logic [INST_W-1:0] NOP_INST   = 32'h0000_0013;

endpackage

// File: rtl/ysyx_22050133_sync_fifo.sv
// Synchronous FIFO with synchronous clear and occupancy count.
module ysyx_22050133_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_en, pop_en;

    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push_en) - CW'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;

endmodule

// File: rtl/ysyx_22050133_fetch_queue.sv
// Decoupled fetch engine: credit-limited in-order requests, PC-tagged instruction queue,
// redirect flush with silent discard of stale responses.
module ysyx_22050133_fetch_queue
    import ysyx_22050133_fetch_queue_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     MEMW     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid_i,
    input  logic [XLEN-1:0]   redirect_pc_i,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [XLEN-1:0]   imem_req_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [MEMW-1:0]   imem_rsp_data_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [XLEN-1:0]   inst_pc_o
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned QW = XLEN + INST_W;

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic [CW-1:0]     inst_count;
    logic [CW:0]       occupancy;
    logic              credit, req_fire, rsp_live, inst_empty, inst_pop;
    logic [XLEN-1:0]   rsp_pc;
    logic [INST_W-1:0] rsp_word;
    logic [QW-1:0]     inst_head;

    logic          redirect_lsb_unused;
    logic          pc_fifo_empty_unused, pc_fifo_full_unused, inst_fifo_full_unused;
    logic [CW-1:0] pc_fifo_count_unused;

    assign redirect_lsb_unused = ^redirect_pc_i[1:0];

    // In-flight requests (stale included) count against the queue so responses never stall.
    assign occupancy        = {1'b0, inst_count} + {1'b0, inflight_q};
    assign credit           = occupancy < (CW + 1)'(DEPTH);
    assign imem_req_valid_o = credit & ~redirect_valid_i & ~rst;
    assign imem_req_addr_o  = fetch_pc_q;
    assign req_fire         = imem_req_valid_o & imem_req_ready_i;
    assign rsp_live         = imem_rsp_valid_i & (discard_q == '0) & ~redirect_valid_i;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
        discard_d  = discard_q;
        if (redirect_valid_i) begin
            fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
            discard_d  = inflight_q - CW'(imem_rsp_valid_i);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (imem_rsp_valid_i && discard_q != '0) discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    generate
        if (MEMW == 64) begin : g_word64
            assign rsp_word = rsp_pc[2] ? imem_rsp_data_i[MEMW-1:32] : imem_rsp_data_i[31:0];
        end else begin : g_word32
            assign rsp_word = imem_rsp_data_i[31:0];
        end
    endgenerate

    ysyx_22050133_sync_fifo #(
        .WIDTH(XLEN),
        .DEPTH(DEPTH)
    ) u_pc_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (redirect_valid_i),
        .push     (req_fire),
        .push_data(fetch_pc_q),
        .pop      (rsp_live),
        .pop_data (rsp_pc),
        .empty    (pc_fifo_empty_unused),
        .full     (pc_fifo_full_unused),
        .count    (pc_fifo_count_unused)
    );

    ysyx_22050133_sync_fifo #(
        .WIDTH(QW),
        .DEPTH(DEPTH)
    ) u_inst_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (redirect_valid_i),
        .push     (rsp_live),
        .push_data({rsp_pc, rsp_word}),
        .pop      (inst_pop),
        .pop_data (inst_head),
        .empty    (inst_empty),
        .full     (inst_fifo_full_unused),
        .count    (inst_count)
    );

    assign inst_valid_o = ~inst_empty & ~redirect_valid_i;
    assign inst_pop     = inst_valid_o & inst_ready_i;
    assign inst_o       = inst_empty ? '0 : inst_head[INST_W-1:0];
    assign inst_pc_o    = inst_empty ? '0 : inst_head[QW-1:INST_W];

endmodule

// File: tb/tb_ysyx_22050133_fetch_queue.sv
// Bench for the fetch queue: memory model with variable latency, queue-level reference model,
// and directed cases with hand-computed PCs and instruction words.
module tb_ysyx_22050133_fetch_queue;
    localparam int DEPTH = 4;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid_i = 1'b0;
    logic [63:0] redirect_pc_i = '0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [63:0] imem_req_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [63:0] imem_rsp_data_i = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [63:0] inst_pc_o;

    ysyx_22050133_fetch_queue dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i   (redirect_pc_i),
        .imem_req_valid_o(imem_req_valid_o),
        .imem_req_ready_i(imem_req_ready_i),
        .imem_req_addr_o (imem_req_addr_o),
        .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i (imem_rsp_data_i),
        .inst_valid_o    (inst_valid_o),
        .inst_ready_i    (inst_ready_i),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    pend_t       pending[$];  // accepted, not yet answered by memory
    logic [63:0] mq[$];       // PCs the decode side should see, in order
    logic [63:0] fpc = RESET_PC;

    int n_checks = 0;
    int n_bad    = 0;
    int n_deliv  = 0;
    int cyc      = 0;
    int lat_min  = 1;
    int lat_max  = 1;
    int mem_pct  = 100;
    int cons_pct = 100;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] img(logic [63:0] a);
        return a[31:0] ^ 32'hDEAD_BEEF;
    endfunction

    function automatic logic [63:0] line_of(logic [63:0] a);
        logic [63:0] b;
        b = {a[63:3], 3'b000};
        return {img(b + 64'd4), img(b)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid_i = 1'b0;
        if (!rst && pending.size() > 0 && pending[0].due <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = line_of(pending[0].addr);
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = '0;
        end
        imem_req_ready_i = int'($urandom_range(99)) < mem_pct;
        inst_ready_i     = int'($urandom_range(99)) < cons_pct;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int k, output bit found);
        found = 1'b0;
        k = 0;
        while (!found && k < limit) begin
            tick();
            k++;
            #3;
            found = inst_valid_o;
        end
    endtask

    // Reference model: checks every cycle at the falling edge, then advances.
    always @(negedge clk) begin : cmp
        logic  exp_req, exp_iv;
        pend_t e;
        if (rst) begin
            pending.delete();
            mq.delete();
            fpc = RESET_PC;
            chk("req_valid_in_reset", 64'(imem_req_valid_o), 64'(0));
        end else begin
            exp_req = !redirect_valid_i && (mq.size() + pending.size() < DEPTH);
            exp_iv  = (mq.size() > 0) && !redirect_valid_i;
            chk("req_valid", 64'(imem_req_valid_o), 64'(exp_req));
            chk("req_addr", imem_req_addr_o, fpc);
            chk("inst_valid", 64'(inst_valid_o), 64'(exp_iv));
            if (exp_iv) begin
                chk("inst_pc", inst_pc_o, mq[0]);
                chk("inst", 64'(inst_o), 64'(img(mq[0])));
            end else if (mq.size() == 0) begin
                chk("empty_pc", inst_pc_o, 64'(0));
                chk("empty_inst", 64'(inst_o), 64'(0));
            end
            if (imem_rsp_valid_i && pending.size() > 0) begin
                e = pending.pop_front();
                if (!e.stale && !redirect_valid_i) mq.push_back(e.addr);
            end
            if (exp_iv && inst_ready_i) begin
                void'(mq.pop_front());
                n_deliv++;
            end
            if (imem_req_valid_o && imem_req_ready_i) begin
                pending.push_back('{fpc, cyc + int'($urandom_range(lat_max, lat_min)), 1'b0});
                fpc = fpc + 64'd4;
            end
            if (redirect_valid_i) begin
                mq.delete();
                foreach (pending[i]) pending[i].stale = 1'b1;
                fpc = {redirect_pc_i[63:2], 2'b00};
            end
        end
    end

    initial begin
        int  reqs;
        int  k;
        bit  found;

        // Reset and streaming with 1-cycle memory.
        do_reset();
        #3;
        chk("t1_first_req_valid", 64'(imem_req_valid_o), 64'(1));
        chk("t1_first_addr", imem_req_addr_o, 64'h8000_0000);
        chk("t1_reset_inst_valid", 64'(inst_valid_o), 64'(0));
        chk("t1_reset_inst", 64'(inst_o), 64'(0));
        chk("t1_reset_pc", inst_pc_o, 64'(0));
        tick();
        tick();
        #3;
        chk("t1_pc0", inst_pc_o, 64'h8000_0000);
        chk("t1_inst0", 64'(inst_o), 64'h5EAD_BEEF);
        tick();
        #3;
        chk("t1_pc1", inst_pc_o, 64'h8000_0004);
        chk("t1_inst1", 64'(inst_o), 64'h5EAD_BEEB);
        tick();
        #3;
        chk("t1_pc2", inst_pc_o, 64'h8000_0008);
        chk("t1_inst2", 64'(inst_o), 64'h5EAD_BEE7);

        // Consumer stalled: credit caps requests at DEPTH.
        cons_pct = 0;
        do_reset();
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            #3;
            if (imem_req_valid_o && imem_req_ready_i) reqs++;
            tick();
        end
        #3;
        chk("t2_req_count", 64'(reqs), 64'(4));
        chk("t2_full_valid", 64'(inst_valid_o), 64'(1));
        chk("t2_no_req_full", 64'(imem_req_valid_o), 64'(0));
        inst_ready_i = 1'b1;
        cons_pct = 100;
        tick();
        #3;
        chk("t2_req_after_pop", 64'(imem_req_valid_o), 64'(1));

        // 3-cycle memory, redirect with three responses outstanding.
        lat_min = 3;
        lat_max = 3;
        do_reset();
        repeat (3) tick();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_0100;
        #3;
        chk("t3_valid_in_redirect", 64'(inst_valid_o), 64'(0));
        wait_valid(20, k, found);
        chk("t3_found", 64'(found), 64'(1));
        chk("t3_latency", 64'(k), 64'(5));
        chk("t3_pc", inst_pc_o, 64'h8000_0100);
        chk("t3_inst", 64'(inst_o), 64'h5EAD_BFEF);

        // Redirect coinciding with a response and a consumer pop.
        lat_min = 1;
        lat_max = 1;
        do_reset();
        repeat (4) tick();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_0200;
        #3;
        chk("t4_valid_in_redirect", 64'(inst_valid_o), 64'(0));
        tick();
        #3;
        chk("t4_empty_after", 64'(inst_valid_o), 64'(0));
        chk("t4_pc_zero_after", inst_pc_o, 64'(0));
        wait_valid(20, k, found);
        chk("t4_found", 64'(found), 64'(1));
        chk("t4_pc", inst_pc_o, 64'h8000_0200);
        chk("t4_inst", 64'(inst_o), 64'h5EAD_BCEF);

        // Unaligned redirect target and PC wrap-around.
        tick();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'h8000_0102;
        tick();
        #3;
        chk("t5_aligned_addr", imem_req_addr_o, 64'h8000_0100);
        tick();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        #3;
        chk("t5_top_addr", imem_req_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_valid(20, k, found);
        chk("t5_found", 64'(found), 64'(1));
        chk("t5_pc_top", inst_pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_inst_top", 64'(inst_o), 64'h2152_4113);
        tick();
        #3;
        chk("t5_pc_wrapped", inst_pc_o, 64'h0);

        // Random ready/latency with redirects and occasional reset.
        lat_min  = 1;
        lat_max  = 4;
        mem_pct  = 70;
        cons_pct = 60;
        n_deliv  = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst = $urandom_range(999) < 3;
            if (!rst && $urandom_range(99) < 3) begin
                redirect_valid_i = 1'b1;
                redirect_pc_i    = 64'h8000_0000 + 64'($urandom_range(255));
            end
        end
        rst = 1'b0;
        chk("t6_progress", 64'(n_deliv > 300), 64'(1));

        mem_pct  = 100;
        cons_pct = 100;
        lat_max  = 1;
        repeat (10) tick();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22050133_fetch_queue.md
# ysyx_22050133_fetch_queue

Parametrised instruction-fetch front end that replaces the single-entry fetch register with a decoupled fetch engine. It issues in-order instruction-memory requests over a valid/ready bus, keeps several requests in flight, and buffers returned instructions with their PCs in a DEPTH-entry queue. A redirect from the back end flushes the queue and silently drops stale in-flight responses. It sits between the instruction memory port and the decode stage.

## Interface
- XLEN, 64, address and PC width.
- RESET_PC, XLEN'h8000_0000, first fetch address after reset.
- DEPTH, 4, instruction queue entries and in-flight request limit; power of 2, at least 2.
- MEMW, 64, memory data width; 32 or 64.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- redirect_valid_i  in  1  flush and restart fetch at redirect_pc_i.
- redirect_pc_i  in  XLEN  new PC; bits [1:0] ignored (treated as 0).
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts request.
- imem_req_addr_o  out  XLEN  fetch address, always 4-byte aligned.
- imem_rsp_valid_i  in  1  response valid; in order, exactly one per accepted request, no earlier than the cycle after acceptance.
- imem_rsp_data_i  in  MEMW  response data.
- inst_valid_o  out  1  queue head valid.
- inst_ready_i  in  1  decode consumes head.
- inst_o  out  32  instruction.
- inst_pc_o  out  XLEN  PC of inst_o.

## Operation
- State: fetch_pc, inflight count (accepted, not yet responded, including stale), discard count, pc FIFO (PCs of live in-flight requests), inst FIFO ({pc, inst}).
- Credit: request allowed when inst_count + inflight < DEPTH, so every live response is guaranteed a queue slot; no response backpressure exists.
- imem_req_valid_o = credit & ~redirect_valid_i & ~rst; addr = fetch_pc.
- Request accepted (valid & ready): fetch_pc += 4 (wraps modulo 2^XLEN), push fetch_pc into pc FIFO, inflight += 1.
- Response with discard > 0: dropped, discard -= 1, inflight -= 1, pc FIFO untouched.
- Response with discard == 0: pop pc FIFO, push {pc, word} into inst FIFO, inflight -= 1. Word = MEMW==64 ? (pc[2] ? data[63:32] : data[31:0]) : data[31:0].
- Redirect: fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b0}; inst FIFO and pc FIFO cleared; discard <= inflight - imem_rsp_valid_i; a response in the redirect cycle is dropped. Redirect has priority over every other event that cycle.
- inst_valid_o = inst FIFO non-empty & ~redirect_valid_i; a pop happens only on inst_valid_o & inst_ready_i.
- Simultaneous push and pop on a full inst FIFO cannot occur (credit rule); simultaneous push and pop otherwise keep count unchanged.

## Timing
- Reset: fetch_pc = RESET_PC, all counts 0, both FIFOs empty, imem_req_valid_o = 0, inst_valid_o = 0, inst_o = 0, inst_pc_o = 0 while empty.
- First request: imem_req_valid_o = 1 in the first cycle with rst low.
- Response at cycle t -> inst_valid_o at t+1 (registered queue, no bypass).
- With single-cycle memory and inst_ready_i = 1, sustained throughput is one instruction per cycle.
- Redirect at cycle t -> request to the new PC may issue at t+1; first new instruction visible at ≥ t+3.
- Back-to-back redirects: each reloads discard from the current inflight; earlier discard value overwritten (inflight already includes it).
- rst mid-operation: all state returns to reset values the next cycle; memory side is reset by the same rst.

## Structure
- Shared package: RESET_PC default, instruction width (32), NOP encoding constant.
- One sub-module: ysyx_22050133_sync_fifo (parametrised WIDTH, DEPTH, synchronous clear, count output), instantiated for the pc FIFO and the inst FIFO.
- Counters are clog2(DEPTH+1) bits wide.

## Test plan
- Reset, 1-cycle memory, ready=1: inst_pc_o sequence 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles; inst_o selects upper/lower word by pc[2].
- inst_ready_i = 0 for 20 cycles: exactly 4 requests issued, inst FIFO full, imem_req_valid_o = 0 until first pop.
- 3-cycle memory latency, 3 requests in flight, redirect to 0x8000_0100: 3 responses dropped, next inst_pc_o = 0x8000_0100.
- Redirect in same cycle as a response and a consumer pop: response dropped, inst_valid_o = 0 that cycle, queue empty next cycle.
- Redirect to 0x8000_0102: imem_req_addr_o = 0x8000_0100.
- Random memory ready/latency plus random redirects vs reference PC model: every delivered (pc, inst) matches memory image, no PC skipped or duplicated.
